// File: rtl/mem_write_pkg.sv
// Shared definitions for the buffered memory write queue.
// Holds the write FSM state type, the input-width helper and the field
// offsets of a queued entry laid out as {flag (optional), addr, data}.
package mem_write_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_e;

    // Data always occupies the LSBs of an entry.
    localparam int DATA_OFS = 0;

    // Address sits directly above the data field.
    function automatic int addr_ofs(input int data_w);
        return data_w;
    endfunction

    // Update flag (when present) is the entry MSB.
    function automatic int flag_ofs(input int addr_w, input int data_w);
        return addr_w + data_w;
    endfunction

    function automatic int calc_in_w(input int addr_w, input int data_w, input bit use_flag);
        return use_flag ? (1 + addr_w + data_w) : (addr_w + data_w);
    endfunction

endpackage

// File: rtl/mem_write_queue_fifo.sv
// sync_fifo: single-clock FIFO with registered pointers.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset (empties the FIFO)
//   push, wdata: write strobe and entry (caller must not push when full)
//   pop, rdata : read strobe and head entry (rdata valid when !empty)
//   full, empty: occupancy flags derived from the pointers only
// Pointers carry one extra wrap bit: equal indices with equal wrap bits
// means empty, equal indices with different wrap bits means full.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]) &&
                   (wr_ptr[PTR_W] != rd_ptr[PTR_W]);
    assign rdata = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset; the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[PTR_W-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/mem_write_queue.sv
// mem_write_queue: buffers {flag, addr, data} entries and issues one memory
// write at a time; entries with a clear flag are dropped without a write.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   data_i, valid_i     : incoming entry and its valid
//   ready_o             : queue not full (registered state only)
//   mem_write           : write request, held until mem_resp
//   mem_addr, mem_wdata : write address/data, held between writes
//   mem_resp            : memory write complete (ignored while idle)
//   done                : queue empty and no write in flight
//   wr_count            : completed writes (wraps)
//   skip_count          : dropped entries (wraps)
// Handshake: an entry is accepted on a clk edge where valid_i & ready_o.
// A write is outstanding from mem_write rising until the edge that samples
// mem_resp high; mem_write drops on the following cycle.
module mem_write_queue
    import mem_write_pkg::*;
#(
    parameter int ADDR_W   = 64,
    parameter int DATA_W   = 64,
    parameter bit USE_FLAG = 1'b1,
    parameter int IN_W     = calc_in_w(ADDR_W, DATA_W, USE_FLAG),
    parameter int DEPTH    = 4,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IN_W-1:0]   data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_resp,
    output logic              done,
    output logic [CNT_W-1:0]  wr_count,
    output logic [CNT_W-1:0]  skip_count
);

    localparam int ADDR_OFS = addr_ofs(DATA_W);
    localparam int FLAG_OFS = flag_ofs(ADDR_W, DATA_W);

    state_e            state;
    logic [IN_W-1:0]   head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              head_flag;

    // When full no push is taken, even if a pop happens in the same cycle.
    assign ready_o = ~fifo_full;
    assign push    = valid_i & ~fifo_full;
    // The head is consumed in IDLE whether it is written or skipped.
    assign pop     = (state == IDLE) & ~fifo_empty;
    assign done    = fifo_empty & (state == IDLE);

    generate
        if (USE_FLAG) begin : g_flag
            assign head_flag = head[FLAG_OFS];
        end else begin : g_no_flag
            assign head_flag = 1'b1;
        end
    endgenerate

    sync_fifo #(
        .WIDTH (IN_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (data_i),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            wr_count   <= '0;
            skip_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        if (!head_flag) begin
                            // Dropped entry: output registers keep the last write.
                            skip_count <= skip_count + CNT_W'(1);
                        end else begin
                            mem_addr  <= head[ADDR_OFS +: ADDR_W];
                            mem_wdata <= head[DATA_OFS +: DATA_W];
                            mem_write <= 1'b1;
                            state     <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (mem_resp) begin
                        wr_count  <= wr_count + CNT_W'(1);
                        mem_write <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    mem_write <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_write_queue.sv
// Directed bench for mem_write_queue. Two instances: dut_a with defaults
// (flagged entries, 16-bit counters) and dut_b with no flag and 2-bit
// counters. use_nf selects which instance the driver tasks talk to.
module tb_mem_write_queue;

    logic         clk;
    logic         rst_n;
    logic [128:0] din;
    logic         valid_i;
    logic         mem_resp;
    logic         use_nf;

    // dut_a outputs
    logic         rdy_a, mw_a, dn_a;
    logic [63:0]  ma_a, md_a;
    logic [15:0]  wc_a, sc_a;
    // dut_b outputs
    logic         rdy_b, mw_b, dn_b;
    logic [63:0]  ma_b, md_b;
    logic [1:0]   wc_b, sc_b;

    // selected-instance view
    logic         rdy, mw, dn;
    logic [63:0]  ma, md;
    logic [15:0]  wc, sc;

    logic [127:0] exp_q[$];
    int           n_vec;
    int           n_err;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    mem_write_queue dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_i     (din),
        .valid_i    (valid_i & ~use_nf),
        .ready_o    (rdy_a),
        .mem_write  (mw_a),
        .mem_addr   (ma_a),
        .mem_wdata  (md_a),
        .mem_resp   (mem_resp & ~use_nf),
        .done       (dn_a),
        .wr_count   (wc_a),
        .skip_count (sc_a)
    );

    mem_write_queue #(
        .USE_FLAG (1'b0),
        .CNT_W    (2)
    ) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_i     (din[127:0]),
        .valid_i    (valid_i & use_nf),
        .ready_o    (rdy_b),
        .mem_write  (mw_b),
        .mem_addr   (ma_b),
        .mem_wdata  (md_b),
        .mem_resp   (mem_resp & use_nf),
        .done       (dn_b),
        .wr_count   (wc_b),
        .skip_count (sc_b)
    );

    assign rdy = use_nf ? rdy_b : rdy_a;
    assign mw  = use_nf ? mw_b  : mw_a;
    assign dn  = use_nf ? dn_b  : dn_a;
    assign ma  = use_nf ? ma_b  : ma_a;
    assign md  = use_nf ? md_b  : md_a;
    assign wc  = use_nf ? {14'd0, wc_b} : wc_a;
    assign sc  = use_nf ? {14'd0, sc_b} : sc_a;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks (operate on negedges) ----------------
    task automatic do_reset();
        rst_n    = 1'b0;
        valid_i  = 1'b0;
        mem_resp = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_q.delete();
    endtask

    // One entry; returns on the negedge after it was accepted.
    task automatic push(input logic flag, input logic [63:0] addr, input logic [63:0] data);
        int waited;
        waited = 0;
        while (!rdy && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!rdy) begin
            check("push_ready_timeout", 64'(rdy), 64'd1);
        end else begin
            din     = {flag, addr, data};
            valid_i = 1'b1;
            if (flag || use_nf) exp_q.push_back({addr, data});
            @(negedge clk);
            valid_i = 1'b0;
        end
    endtask

    // Wait for a write, compare it with the scoreboard head, answer it.
    task automatic serve(input string tag);
        logic [127:0] e;
        int waited;
        waited = 0;
        while (!mw && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_write_seen"}, 64'(mw), 64'd1);
        if (mw) begin
            if (exp_q.size() == 0) begin
                check({tag, "_unexpected_write"}, 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                check({tag, "_addr"}, ma, e[127:64]);
                check({tag, "_data"}, md, e[63:0]);
            end
            mem_resp = 1'b1;
            @(negedge clk);
            mem_resp = 1'b0;
        end
    endtask

    // ---------------- directed tests ----------------
    initial begin
        n_vec    = 0;
        n_err    = 0;
        use_nf   = 1'b0;
        din      = '0;
        valid_i  = 1'b0;
        mem_resp = 1'b0;
        rst_n    = 1'b0;

        // Reset values
        do_reset();
        check("rst_ready",  64'(rdy), 64'd1);
        check("rst_done",   64'(dn),  64'd1);
        check("rst_mw",     64'(mw),  64'd0);
        check("rst_addr",   ma,       64'd0);
        check("rst_wdata",  md,       64'd0);
        check("rst_wr",     64'(wc),  64'd0);
        check("rst_skip",   64'(sc),  64'd0);

        // Single write: latency and done timing
        push(1'b1, 64'h100, 64'hAA);
        check("t1_c1_mw",   64'(mw), 64'd0);
        check("t1_c1_done", 64'(dn), 64'd0);
        @(negedge clk);
        check("t1_c2_mw",   64'(mw), 64'd1);
        check("t1_c2_addr", ma, 64'h100);
        check("t1_c2_data", md, 64'hAA);
        void'(exp_q.pop_front());
        repeat (3) @(negedge clk);
        check("t1_hold_mw", 64'(mw), 64'd1);
        mem_resp = 1'b1;
        @(negedge clk);
        mem_resp = 1'b0;
        check("t1_done",    64'(dn), 64'd1);
        check("t1_mw_low",  64'(mw), 64'd0);
        check("t1_wr",      64'(wc), 64'd1);

        // Fill: 5 back-to-back pushes with no response
        do_reset();
        for (int i = 0; i < 5; i++) push(1'b1, 64'h200 + 64'(i), 64'h5000 + 64'(i));
        check("t2_full_ready", 64'(rdy), 64'd0);
        check("t2_mw",         64'(mw),  64'd1);
        check("t2_first_addr", ma,       64'h200);
        for (int i = 0; i < 5; i++) serve("t2");
        repeat (2) @(negedge clk);
        check("t2_wr",   64'(wc), 64'd5);
        check("t2_done", 64'(dn), 64'd1);

        // Skips: flags 0,0,1,0
        do_reset();
        push(1'b0, 64'h10, 64'h30);
        push(1'b0, 64'h11, 64'h31);
        push(1'b1, 64'h12, 64'h32);
        push(1'b0, 64'h13, 64'h33);
        serve("t3");
        repeat (3) @(negedge clk);
        check("t3_skip", 64'(sc), 64'd3);
        check("t3_wr",   64'(wc), 64'd1);
        check("t3_addr", ma,      64'h12);
        check("t3_data", md,      64'h32);
        check("t3_done", 64'(dn), 64'd1);

        // Reset in the middle of a write with 2 entries queued
        do_reset();
        push(1'b1, 64'h400, 64'h1);
        push(1'b1, 64'h401, 64'h2);
        push(1'b1, 64'h402, 64'h3);
        check("t5_inflight", 64'(mw), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mem_resp = 1'b1;
        @(negedge clk);
        mem_resp = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_mw",    64'(mw), 64'd0);
        check("t5_done",  64'(dn), 64'd1);
        check("t5_wr",    64'(wc), 64'd0);
        check("t5_skip",  64'(sc), 64'd0);
        check("t5_ready", 64'(rdy), 64'd1);
        exp_q.delete();

        // No-flag build: flag bit ignored, 2-bit counters wrap
        use_nf = 1'b1;
        do_reset();
        check("t4_rst_done", 64'(dn), 64'd1);
        push(1'b0, 64'h700, 64'h70);
        push(1'b1, 64'h701, 64'h71);
        push(1'b0, 64'h702, 64'h72);
        for (int i = 0; i < 3; i++) serve("t4");
        repeat (2) @(negedge clk);
        check("t4_wr",   64'(wc), 64'd3);
        check("t4_skip", 64'(sc), 64'd0);
        push(1'b0, 64'h703, 64'h73);
        push(1'b0, 64'h704, 64'h74);
        for (int i = 0; i < 2; i++) serve("t6");
        repeat (2) @(negedge clk);
        check("t6_wr_wrap", 64'(wc), 64'd1);
        check("t6_skip",    64'(sc), 64'd0);
        check("t6_done",    64'(dn), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
